// File: rtl/fifo_arb_pkg.sv
// Shared defaults and width helpers for the FIFO write arbiter.
package fifo_arb_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 32;
  localparam int DEPTH_DEF   = 16;
  localparam int CNT_W       = 16;

  // Width of an occupancy count able to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after rr_ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] rr_ptr,
  output logic [N-1:0]  winner,
  output logic [PW-1:0] win_idx,
  output logic          valid
);
  // Rotate search from rr_ptr upward; the first hit wins.
  always_comb begin
    winner  = '0;
    win_idx = '0;
    valid   = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (int'(rr_ptr) + k) % N;
      if (!valid && eligible[j]) begin
        valid      = 1'b1;
        winner[j]  = 1'b1;
        win_idx    = PW'(j);
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter merging NUM_REQ producers into one FIFO write port.
// Registered outputs, one-cycle latency, credit-checked against fifo_count.
// Optional per-requester grant counters when FIFO_WR_ARB_STATS_EN is defined.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  input  logic [cnt_w(DEPTH)-1:0]     fifo_count,
  output logic                        fifo_wr_en,
`ifdef FIFO_WR_ARB_STATS_EN
  output logic [NUM_REQ*CNT_W-1:0]    gnt_cnt,
`endif
  output logic [DATA_W-1:0]           fifo_din
);
  localparam int CW = cnt_w(DEPTH);
  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]      rr_ptr;
  logic [NUM_REQ-1:0] eligible, winner;
  logic [PW-1:0]      win_idx;
  logic               win_vld;
  logic [CW:0]        occ;
  logic               credit_ok, grant_now;

  // A word granted this cycle is not yet consumed by the producer, so mask it out.
  assign eligible  = req & ~gnt;
  // Conservative credit: the write in flight counts as occupied, reads are ignored.
  assign occ       = {1'b0, fifo_count} + (CW+1)'(fifo_wr_en);
  assign credit_ok = occ < (CW+1)'(DEPTH);
  assign grant_now = win_vld && credit_ok;

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .eligible(eligible),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .win_idx (win_idx),
    .valid   (win_vld)
  );

  // Register the grant, write strobe and data; pointer advances past the winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt        <= '0;
      fifo_wr_en <= 1'b0;
      fifo_din   <= '0;
      rr_ptr     <= '0;
    end else if (grant_now) begin
      gnt        <= winner;
      fifo_wr_en <= 1'b1;
      fifo_din   <= req_data[win_idx*DATA_W +: DATA_W];
      rr_ptr     <= (win_idx == PW'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
    end else begin
      gnt        <= '0;
      fifo_wr_en <= 1'b0;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
    logic [CNT_W-1:0] cnt;
    // Saturating count of grants issued to this requester.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                  cnt <= '0;
      else if (grant_now && winner[gi] && cnt != '1) cnt <= cnt + 1'b1;
    end
    assign gnt_cnt[gi*CNT_W +: CNT_W] = cnt;
  end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter against a spec-level reference model.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int D  = 16;
  localparam int CW = $clog2(D) + 1;

  logic              clk = 0;
  logic              rst = 1;
  logic [N-1:0]      req = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      gnt;
  logic [CW-1:0]     fifo_count = '0;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_din;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [N*16-1:0]   gnt_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_ptr;
  int          m_last;     // requester granted in the current cycle, -1 if none
  bit          m_wr;
  logic [DW-1:0] m_din;
  int          m_cnt [N];

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_count(fifo_count), .fifo_wr_en(fifo_wr_en),
`ifdef FIFO_WR_ARB_STATS_EN
    .gnt_cnt(gnt_cnt),
`endif
    .fifo_din(fifo_din)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_ptr = 0; m_last = -1; m_wr = 0; m_din = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  // Predict the outcome of the next edge from current inputs, clock it, compare.
  task automatic step(input string nm);
    int win;
    bit credit;
    logic [N-1:0] exp_gnt;
    win = -1;
    credit = (int'(fifo_count) + int'(m_wr)) < D;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (win < 0 && req[i] && i != m_last) win = i;
    end
    if (credit && win >= 0) begin
      m_last = win; m_wr = 1; m_din = req_data[win*DW +: DW];
      m_ptr = (win + 1) % N;
      if (m_cnt[win] < 16'hFFFF) m_cnt[win]++;
    end else begin
      m_last = -1; m_wr = 0;
    end
    exp_gnt = (m_last >= 0) ? (N'(1) << m_last) : '0;
    @(posedge clk); #1;
    total++;
    if (gnt !== exp_gnt || fifo_wr_en !== m_wr || fifo_din !== m_din) begin
      bad++;
      $display("FAIL %s: gnt=%b wr_en=%b din=%h required gnt=%b wr_en=%b din=%h",
               nm, gnt, fifo_wr_en, fifo_din, exp_gnt, m_wr, m_din);
    end
  endtask

  task automatic do_reset();
    rst = 1; req = '0; fifo_count = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1; req = '1; req_data = {N{32'hDEAD_BEEF}};
    repeat (2) @(posedge clk); #1;
    total++;
    if (gnt !== '0 || fifo_wr_en !== 1'b0 || fifo_din !== '0) begin
      bad++;
      $display("FAIL reset: gnt=%b wr_en=%b din=%h required 0/0/0", gnt, fifo_wr_en, fifo_din);
    end
    rst = 0; req = '0; model_reset();
  endtask

  task automatic test_all_req();
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 32'hA000_0000 + i;
    req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      step("all_req");
      total++;
      if (gnt !== (N'(1) << order[c]) || fifo_din !== 32'hA000_0000 + order[c]) begin
        bad++;
        $display("FAIL all_req_order: cycle %0d gnt=%b din=%h required idx %0d", c, gnt, fifo_din, order[c]);
      end
    end
    req = '0; step("all_req_idle");
  endtask

  task automatic test_single();
    logic [DW-1:0] sent [$];
    logic [DW-1:0] got [$];
    logic [DW-1:0] d;
    do_reset();
    d = 32'h5000_0000;
    req = 4'b0100; req_data[2*DW +: DW] = d; sent.push_back(d);
    for (int c = 0; c < 10; c++) begin
      step("single");
      if (fifo_wr_en) got.push_back(fifo_din);
      if (gnt[2]) begin
        d = d + 1; req_data[2*DW +: DW] = d; sent.push_back(d);
      end
    end
    total++;
    if (got.size() != 5) begin
      bad++; $display("FAIL single_rate: writes=%0d required 5", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      total++;
      if (got[i] !== sent[i]) begin
        bad++; $display("FAIL single_word%0d: got=%h required %h", i, got[i], sent[i]);
      end
    end
    req = '0; step("single_idle");
  endtask

  task automatic test_credit();
    do_reset();
    req_data[0 +: DW] = 32'hC0; req_data[DW +: DW] = 32'hC1;
    fifo_count = 15; req = 4'b0011;
    step("credit_first");
    total++;
    if (fifo_wr_en !== 1'b1) begin
      bad++; $display("FAIL credit_grant: wr_en=%b required 1", fifo_wr_en);
    end
    step("credit_full_inflight");
    total++;
    if (gnt !== '0) begin
      bad++; $display("FAIL credit_block: gnt=%b required 0", gnt);
    end
    fifo_count = 16;
    step("credit_full");
    step("credit_full2");
    fifo_count = 14;
    step("credit_resume");
    total++;
    if (fifo_wr_en !== 1'b1) begin
      bad++; $display("FAIL credit_resume: wr_en=%b required 1", fifo_wr_en);
    end
    req = '0; fifo_count = 0; step("credit_idle");
  endtask

  task automatic test_wrap();
    do_reset();
    req_data[0 +: DW] = 32'h0; req_data[DW +: DW] = 32'h1;
    req = 4'b0010; step("wrap_g1");
    req = 4'b0011; step("wrap_g0");
    total++;
    if (gnt !== 4'b0001) begin
      bad++; $display("FAIL wrap: gnt=%b required 0001", gnt);
    end
    req = '0; step("wrap_idle");
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 32'hB000_0000 + i;
    req = 4'b1000; step("mid_pre");
    rst = 1; #1;
    total++;
    if (fifo_wr_en !== 1'b0 || gnt !== '0) begin
      bad++; $display("FAIL reset_mid: wr_en=%b gnt=%b required 0/0", fifo_wr_en, gnt);
    end
    @(posedge clk); #1;
    rst = 0; model_reset();
    req = 4'b0110; step("mid_after");
    total++;
    if (gnt !== 4'b0010) begin
      bad++; $display("FAIL reset_mid_first: gnt=%b required 0010", gnt);
    end
    req = '0; step("mid_idle");
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req = N'($urandom);
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
      fifo_count = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, D)) : CW'($urandom_range(D-2, D));
      step("random");
    end
    req = '0; fifo_count = 0;
  endtask

`ifdef FIFO_WR_ARB_STATS_EN
  task automatic test_stats();
    for (int i = 0; i < N; i++) begin
      total++;
      if (gnt_cnt[i*16 +: 16] !== 16'(m_cnt[i])) begin
        bad++; $display("FAIL stats%0d: cnt=%0d required %0d", i, gnt_cnt[i*16 +: 16], m_cnt[i]);
      end
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_all_req();
    test_single();
    test_credit();
    test_wrap();
    test_reset_mid();
    test_random();
`ifdef FIFO_WR_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of producer requesters (2..8).
REQ-002 Parameter DATA_W, default 32, SHALL set the word width.
REQ-003 Parameter DEPTH, default 16, SHALL set the downstream FIFO capacity in words.
REQ-004 Port clk  input  1  SHALL be the clock; all state updates on the rising edge.
REQ-005 Port rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-006 Port req  input  NUM_REQ  SHALL carry per-requester write requests.
REQ-007 Port req_data  input  NUM_REQ*DATA_W  SHALL carry the per-requester words; requester i uses slice [i*DATA_W +: DATA_W].
REQ-008 Port gnt  output  NUM_REQ  SHALL signal a one-hot, one-cycle acceptance of the requester's current word.
REQ-009 Port fifo_count  input  $clog2(DEPTH)+1  SHALL carry the FIFO occupancy.
REQ-010 Port fifo_wr_en  output  1  SHALL drive the FIFO write enable.
REQ-011 Port fifo_din  output  DATA_W  SHALL drive the FIFO write data.

Function
REQ-012 At each edge the arbiter SHALL sample req/req_data and register gnt, fifo_wr_en and fifo_din; latency from req to fifo_wr_en is 1 cycle.
REQ-013 The winner SHALL be chosen round-robin: search starts at rr_ptr, ascends and wraps modulo NUM_REQ; on a grant, rr_ptr becomes (winner+1) mod NUM_REQ.
REQ-014 A requester granted in the current cycle (gnt[i]=1) SHALL be excluded from the selection at the next edge; one requester alone thus gets at most one word every 2 cycles.
REQ-015 A grant SHALL issue only if fifo_count + fifo_wr_en < DEPTH; otherwise gnt=0, fifo_wr_en=0 and rr_ptr is held.
REQ-016 Concurrent FIFO reads SHALL NOT be anticipated; the credit check stays conservative.
REQ-017 With no eligible request: gnt=0, fifo_wr_en=0, and fifo_din holds its last value.
REQ-018 On a grant: gnt has exactly one bit set; fifo_wr_en=1; fifo_din = the winner's req_data sampled at that edge.
REQ-019 Requesters SHALL hold req and req_data stable until gnt is seen. The producer may then present a new word after the following edge or drop req.
REQ-020 Dropping req before grant SHALL be legal; the word is not written.

Reset
REQ-021 While rst=1: gnt=0, fifo_wr_en=0, fifo_din=0, rr_ptr=0 (requester 0 has priority first).
REQ-022 Reset mid-operation SHALL cancel any registered grant immediately (asynchronously); that word is not written.
REQ-023 First grant possible at the first edge after rst deasserts.

Configuration
REQ-024 Macro FIFO_WR_ARB_STATS_EN defined: extra output gnt_cnt (NUM_REQ*16), one 16-bit counter per requester. Each counter increments on that requester's grant, saturates at 16'hFFFF and clears on reset.
REQ-025 Macro undefined: gnt_cnt port and counters are absent; all other behaviour is identical.

Structure
REQ-026 Package fifo_arb_pkg SHALL hold the NUM_REQ/DATA_W/DEPTH defaults, the CNT_W=16 constant and the function computing the count width.
REQ-027 Sub-module rr_pick SHALL hold the combinational rotate-and-priority-select: inputs eligible mask and rr_ptr; outputs one-hot winner, winner index and valid.

Verification
REQ-028 After reset, req=4'b1111 with fifo_count=0 -> grants in order 0,1,2,3,0, one per cycle; fifo_din matches each slice.
REQ-029 Only req[2], held continuously with new data after each gnt -> gnt[2] on alternate cycles; no word duplicated.
REQ-030 fifo_count=15 with req=4'b0011 -> exactly one grant; next cycle no grant while count+wr_en=16; grants resume when count drops to 14.
REQ-031 Grant to requester 1, then rr_ptr=2 with req=4'b0011 -> next grant to requester 0 (wrap), not 1.
REQ-032 Assert rst in the cycle fifo_wr_en=1 -> fifo_wr_en and gnt drop before the next edge; after release, first grant goes to the lowest requesting index.
REQ-033 With FIFO_WR_ARB_STATS_EN defined, 70000 grants to requester 0 -> gnt_cnt[15:0]=16'hFFFF; other counters unchanged.
